// File: rtl/conveyor_pkg.sv
// conveyor_pkg: conveyor entry layout and fault codes shared by the conveyor blocks.
package conveyor_pkg;
  localparam int FAULT_ADDR_WIDTH = 3;
  localparam logic [FAULT_ADDR_WIDTH-1:0] F_NONE = '0;
  typedef struct packed {
    logic finished;
    logic [FAULT_ADDR_WIDTH-1:0] fault;
    logic [31:0] value;
  } conveyor_entry_t;
endpackage

// File: rtl/conveyor_writeback_arbiter_rr_pick.sv
// rr_pick: rotate-priority picker; the first valid requester at or after i_start (wrapping) wins.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_valid,
  input  logic [W-1:0] i_start,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  logic [W-1:0] w_c;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c = i_start;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_valid[w_c]) begin
        o_any = 1'b1;
        o_grant[w_c] = 1'b1;
        o_idx = w_c;
      end
      w_c = (w_c == W'(N - 1)) ? '0 : w_c + 1'b1;
    end
  end
endmodule

// File: rtl/conveyor_writeback_arbiter.sv
// conveyor_writeback_arbiter: round-robin owner of the shared conveyor slot-write port.
// CONVEYOR_ARB_MEMFIRST_EN gives requester 0 (memory load return) strict priority.
module conveyor_writeback_arbiter
  import conveyor_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int REQUESTERS = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [REQUESTERS-1:0]                      req_valid,
  output logic [REQUESTERS-1:0]                      req_ready,
  input  logic [REQUESTERS-1:0]                      req_conveyor,
  input  logic [REQUESTERS*CONVEYOR_ADDR_WIDTH-1:0]  req_slot,
  input  logic [REQUESTERS*FAULT_ADDR_WIDTH-1:0]     req_fault,
  input  logic [REQUESTERS*WORD_WIDTH-1:0]           req_value,
  input  logic                                       port_stall,
  output logic                                       wr_en,
  output logic                                       wr_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0]             wr_slot,
  output logic [FAULT_ADDR_WIDTH+WORD_WIDTH:0]       wr_entry,
  output logic [15:0]                                grant_count
);
  localparam int PW = $clog2(REQUESTERS);
  logic [PW-1:0] r_rr_ptr;
  logic [REQUESTERS-1:0] w_rr_valid, w_rr_grant;
  logic [PW-1:0] w_rr_idx, w_idx;
  logic w_rr_any, w_mem, w_accept;
`ifdef CONVEYOR_ARB_MEMFIRST_EN
  assign w_mem = req_valid[0];
  assign w_rr_valid = {req_valid[REQUESTERS-1:1], 1'b0};
`else
  assign w_mem = 1'b0;
  assign w_rr_valid = req_valid;
`endif
  rr_pick #(.N(REQUESTERS), .W(PW)) u_pick (
    .i_valid(w_rr_valid),
    .i_start(r_rr_ptr),
    .o_grant(w_rr_grant),
    .o_idx(w_rr_idx),
    .o_any(w_rr_any)
  );
  assign w_accept = !port_stall && !reset && (w_mem || w_rr_any);
  assign w_idx = w_mem ? '0 : w_rr_idx;
  assign req_ready = !w_accept ? '0 : w_mem ? REQUESTERS'(1) : w_rr_grant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en <= 1'b0;
      wr_conveyor <= 1'b0;
      wr_slot <= '0;
      wr_entry <= {1'b0, F_NONE, WORD_WIDTH'(0)};
      r_rr_ptr <= '0;
      grant_count <= '0;
    end else begin
      wr_en <= w_accept;
      if (w_accept) begin
        wr_conveyor <= req_conveyor[w_idx];
        wr_slot <= req_slot[w_idx*CONVEYOR_ADDR_WIDTH +: CONVEYOR_ADDR_WIDTH];
        wr_entry <= {1'b1, req_fault[w_idx*FAULT_ADDR_WIDTH +: FAULT_ADDR_WIDTH],
                     req_value[w_idx*WORD_WIDTH +: WORD_WIDTH]};
        grant_count <= grant_count + {15'd0, grant_count != 16'hFFFF};
        // memory-first grants leave the rotation among the other units untouched
        if (!w_mem) r_rr_ptr <= (w_rr_idx == PW'(REQUESTERS - 1)) ? '0 : w_rr_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_conveyor_writeback_arbiter.sv
// tb_conveyor_writeback_arbiter: scoreboard bench; a negedge monitor predicts grants and write-port contents.
module tb_conveyor_writeback_arbiter;
`ifdef CONVEYOR_ARB_MEMFIRST_EN
  localparam bit MEMFIRST = 1'b1;
`else
  localparam bit MEMFIRST = 1'b0;
`endif
  typedef struct {
    logic        conv;
    logic [3:0]  slot;
    logic [35:0] entry;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic port_stall = 1'b0;
  logic [3:0] valid = 4'b0;
  logic v_conv[4];
  logic [3:0] v_slot[4];
  logic [2:0] v_fault[4];
  logic [31:0] v_val[4];
  logic [3:0] p_conv, req_ready;
  logic [15:0] p_slot;
  logic [11:0] p_fault;
  logic [127:0] p_val;
  logic wr_en, wr_conveyor;
  logic [3:0] wr_slot;
  logic [35:0] wr_entry;
  logic [15:0] grant_count;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t e;
  int m_ptr = 0;
  int g, j;
  logic [15:0] m_cnt = 16'd0;
  logic [3:0] exp_r;

  always #5 clk = ~clk;

  always_comb begin
    p_conv = '0;
    p_slot = '0;
    p_fault = '0;
    p_val = '0;
    for (int i = 0; i < 4; i++) begin
      p_conv[i] = v_conv[i];
      p_slot[i*4 +: 4] = v_slot[i];
      p_fault[i*3 +: 3] = v_fault[i];
      p_val[i*32 +: 32] = v_val[i];
    end
  end

  conveyor_writeback_arbiter #(.WORD_WIDTH(32), .CONVEYOR_ADDR_WIDTH(4), .REQUESTERS(4)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(valid),
    .req_ready(req_ready),
    .req_conveyor(p_conv),
    .req_slot(p_slot),
    .req_fault(p_fault),
    .req_value(p_val),
    .port_stall(port_stall),
    .wr_en(wr_en),
    .wr_conveyor(wr_conveyor),
    .wr_slot(wr_slot),
    .wr_entry(wr_entry),
    .grant_count(grant_count)
  );

  // reference model: predicts this cycle's grant and checks the write captured last cycle
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_ptr = 0;
      m_cnt = 16'd0;
      checks++;
      if (req_ready !== 4'b0) begin
        errors++;
        $display("FAIL ready_in_reset got %b want 0000", req_ready);
      end
    end else begin
      checks++;
      if (wr_en !== (q.size() != 0)) begin
        errors++;
        $display("FAIL wr_en got %b want %b", wr_en, q.size() != 0);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if ({wr_conveyor, wr_slot, wr_entry} !== {e.conv, e.slot, e.entry}) begin
          errors++;
          $display("FAIL wr_fields got %b/%0d/%h want %b/%0d/%h",
                   wr_conveyor, wr_slot, wr_entry, e.conv, e.slot, e.entry);
        end
      end
      checks++;
      if (grant_count !== m_cnt) begin
        errors++;
        $display("FAIL grant_count got %0d want %0d", grant_count, m_cnt);
      end
      g = -1;
      if (!port_stall) begin
        if (MEMFIRST && valid[0]) g = 0;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (g < 0 && valid[j] && (j != 0 || !MEMFIRST)) g = j;
        end
      end
      exp_r = (g < 0) ? 4'b0 : 4'(1 << g);
      checks++;
      if (req_ready !== exp_r) begin
        errors++;
        $display("FAIL req_ready got %b want %b", req_ready, exp_r);
      end
      if (g >= 0) begin
        q.push_back('{conv: v_conv[g], slot: v_slot[g], entry: {1'b1, v_fault[g], v_val[g]}});
        if (!(MEMFIRST && g == 0)) m_ptr = (g + 1) % 4;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
  end

  task automatic step(input logic [3:0] hold, output logic [3:0] acc);
    @(negedge clk);
    acc = valid & req_ready;
    @(posedge clk);
    #1 valid = valid & (~acc | hold);
  endtask

  task automatic set_req(input int i, input logic c, input logic [3:0] s, input logic [2:0] f,
                         input logic [31:0] v);
    v_conv[i] = c;
    v_slot[i] = s;
    v_fault[i] = f;
    v_val[i] = v;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    valid = 4'b1111;
    @(negedge clk);
    checks++;
    if ({wr_en, wr_conveyor, wr_slot, wr_entry, grant_count} !== 58'd0) begin
      errors++;
      $display("FAIL reset_state got en=%b conv=%b slot=%0d entry=%h cnt=%0d want all zero",
               wr_en, wr_conveyor, wr_slot, wr_entry, grant_count);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    valid = 4'b0;
  endtask

  task automatic test_single();
    logic [3:0] acc;
    @(posedge clk);
    #1 set_req(2, 1'b0, 4'd5, 3'd0, 32'hDEADBEEF);
    valid = 4'b0100;
    step(4'b0, acc);
    checks++;
    if (acc !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant got %b want 0100", acc);
    end
    @(negedge clk);
    checks++;
    if ({wr_en, wr_conveyor, wr_slot, wr_entry} !== {1'b1, 1'b0, 4'd5, 1'b1, 3'd0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_write got en=%b conv=%b slot=%0d entry=%h want 1/0/5/%h",
               wr_en, wr_conveyor, wr_slot, wr_entry, {1'b1, 3'd0, 32'hDEADBEEF});
    end
  endtask

  task automatic test_same_slot();
    logic [3:0] acc;
    @(posedge clk);
    #1 set_req(0, 1'b1, 4'd7, 3'd2, 32'h0000AAAA);
    set_req(3, 1'b1, 4'd7, 3'd0, 32'h33333333);
    valid = 4'b1001;
    step(4'b0, acc);
    checks++;
    if (acc !== 4'b1000) begin
      errors++;
      $display("FAIL same_slot_first got %b want 1000", acc);
    end
    step(4'b0, acc);
    checks++;
    if (acc !== 4'b0001) begin
      errors++;
      $display("FAIL same_slot_second got %b want 0001", acc);
    end
    @(negedge clk);
    checks++;
    if ({wr_en, wr_conveyor, wr_slot, wr_entry[31:0]} !== {1'b1, 1'b1, 4'd7, 32'h0000AAAA}) begin
      errors++;
      $display("FAIL same_slot_final got en=%b conv=%b slot=%0d value=%h want 1/1/7/0000aaaa",
               wr_en, wr_conveyor, wr_slot, wr_entry[31:0]);
    end
  endtask

  task automatic test_stall();
    logic [3:0] acc;
    @(posedge clk);
    @(posedge clk);
    #1 set_req(1, 1'b0, 4'd9, 3'd5, 32'h12345678);
    valid = 4'b0010;
    port_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(4'b0, acc);
      checks++;
      if (acc !== 4'b0 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d got ready=%b en=%b want 0000/0", i, acc, wr_en);
      end
    end
    port_stall = 1'b0;
    step(4'b0, acc);
    checks++;
    if (acc !== 4'b0010) begin
      errors++;
      $display("FAIL stall_release got %b want 0010", acc);
    end
    @(negedge clk);
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_write got en=%b want 1", wr_en);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acc;
    pulse_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'(i), 4'(i + 1), 3'(i), 32'hA0000000 + 32'(i));
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, acc);
      checks++;
      if (acc !== 4'(1 << (i % 4))) begin
        errors++;
        $display("FAIL b2b_grant%0d got %b want %b", i, acc, 4'(1 << (i % 4)));
      end
    end
    @(negedge clk);
    checks++;
    if (grant_count !== 16'd5 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count got cnt=%0d en=%b want 5/1", grant_count, wr_en);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] acc;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({wr_en, grant_count, req_ready} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got en=%b cnt=%0d ready=%b want 0/0/0000", wr_en, grant_count, req_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    step(4'b1111, acc);
    checks++;
    if (acc !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset_ptr got %b want 0001", acc);
    end
    valid = 4'b0;
  endtask

  task automatic test_memfirst();
    logic [3:0] acc;
    logic [3:0] want;
    pulse_reset();
    valid = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, acc);
      want = (MEMFIRST || i != 1) ? 4'b0001 : 4'b0010;
      checks++;
      if (acc !== want) begin
        errors++;
        $display("FAIL memfirst_grant%0d got %b want %b", i, acc, want);
      end
    end
    valid = valid & 4'b1110;
    step(4'b0, acc);
    checks++;
    if (acc !== 4'b0010) begin
      errors++;
      $display("FAIL memfirst_req1 got %b want 0010", acc);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 4'd0, 3'd0, 32'd0);
    test_reset();
    test_single();
    test_same_slot();
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_memfirst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
